mem_arbiter: RTL and testbench

//  Shares the single main-memory port between the I-cache refill path and the D-cache

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between I-cache refills and D-cache refills/write-backs.
// Valid seen in IDLE -> MEM_LATENCY ACCESS cycles -> one RESP cycle; losers simply hold their request.
module mem_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = 128,
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IReqValid,
  input  logic [WORD_SIZE-1:0] IReqAddr,
  input  logic                 DReqValid,
  input  logic                 DReqWrite,
  input  logic [WORD_SIZE-1:0] DReqAddr,
  input  logic [LINE_SIZE-1:0] DReqWData,
  output logic                 IGrant,
  output logic                 DGrant,
  output logic                 IRespValid,
  output logic                 DRespValid,
  output logic [LINE_SIZE-1:0] RespData,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [LINE_SIZE-1:0] MemWData,
  input  logic [LINE_SIZE-1:0] MemRData,
  output logic                 Busy
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          last_d;
  logic          pick_d;

  // On a tie the side that did not win last time goes next.
  always_comb begin
    pick_d = DReqValid && (!IReqValid || !last_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      last_d     <= 1'b0;
      IGrant     <= 1'b0;
      DGrant     <= 1'b0;
      IRespValid <= 1'b0;
      DRespValid <= 1'b0;
      RespData   <= '0;
      MemReq     <= 1'b0;
      MemWrite   <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      Busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IReqValid || DReqValid) begin
            state  <= ACCESS;
            count  <= CW'(MEM_LATENCY - 1);
            last_d <= pick_d;
            IGrant <= !pick_d;
            DGrant <= pick_d;
            MemReq <= 1'b1;
            Busy   <= 1'b1;
            if (pick_d) begin
              MemAddr  <= DReqAddr;
              MemWrite <= DReqWrite;
              MemWData <= DReqWData;
            end else begin
              MemAddr  <= IReqAddr;
              MemWrite <= 1'b0;
              MemWData <= '0;
            end
          end
        end
        ACCESS: begin
          if (count == '0) begin
            state      <= RESP;
            MemReq     <= 1'b0;
            MemWrite   <= 1'b0;
            IRespValid <= IGrant;
            DRespValid <= DGrant;
            // Memory read data is only valid in the final access cycle.
            if (!MemWrite) begin
              RespData <= MemRData;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          IGrant     <= 1'b0;
          DGrant     <= 1'b0;
          IRespValid <= 1'b0;
          DRespValid <= 1'b0;
          Busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single transfers, hand sequences for
// round-robin, mid-transfer reset and the single-cycle-latency variant.
module tb_mem_arbiter;

  localparam logic [127:0] MB = 128'h1000_0000_2000_0000_3000_0000_4000_0000;
  localparam logic [127:0] WB = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  // {IGrant, DGrant, IRespValid, DRespValid, MemReq, MemWrite, Busy}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_ACC_I  = 7'b1000101;
  localparam logic [6:0] O_RSP_I  = 7'b1010001;
  localparam logic [6:0] O_ACC_DW = 7'b0100111;
  localparam logic [6:0] O_RSP_D  = 7'b0101001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ireq = 1'b0;
  logic [31:0]  iaddr = '0;
  logic         dreq = 1'b0;
  logic         dwr = 1'b0;
  logic [31:0]  daddr = '0;
  logic [127:0] dwdata = '0;
  logic [127:0] mrdata = '0;

  logic         ig, dg, irv, drv, mreq, mwr, busy;
  logic [127:0] rdata, mwdata;
  logic [31:0]  maddr;
  logic         l1_ig, l1_dg, l1_irv, l1_drv, l1_mreq, l1_mwr, l1_busy;
  logic [127:0] l1_rdata, l1_mwdata;
  logic [31:0]  l1_maddr;
  logic [6:0]   outs;

  assign outs = {ig, dg, irv, drv, mreq, mwr, busy};

  always #5 clk = ~clk;

  mem_arbiter u0 (
    .clk(clk), .rst(rst),
    .IReqValid(ireq), .IReqAddr(iaddr),
    .DReqValid(dreq), .DReqWrite(dwr), .DReqAddr(daddr), .DReqWData(dwdata),
    .IGrant(ig), .DGrant(dg), .IRespValid(irv), .DRespValid(drv), .RespData(rdata),
    .MemReq(mreq), .MemWrite(mwr), .MemAddr(maddr), .MemWData(mwdata),
    .MemRData(mrdata), .Busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .IReqValid(ireq), .IReqAddr(iaddr),
    .DReqValid(dreq), .DReqWrite(dwr), .DReqAddr(daddr), .DReqWData(dwdata),
    .IGrant(l1_ig), .DGrant(l1_dg), .IRespValid(l1_irv), .DRespValid(l1_drv),
    .RespData(l1_rdata), .MemReq(l1_mreq), .MemWrite(l1_mwr), .MemAddr(l1_maddr),
    .MemWData(l1_mwdata), .MemRData(mrdata), .Busy(l1_busy)
  );

  typedef struct {
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic         dw;
    logic [31:0]  da;
    logic [127:0] wd;
    logic [127:0] mr;
    logic [6:0]   eo;
    logic [31:0]  ea;
    logic [127:0] ew;
    logic [127:0] er;
  } vec_t;

  vec_t tbl[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [127:0] wd, input logic [127:0] mr,
                     input logic [6:0] eo, input logic [31:0] ea, input logic [127:0] ew,
                     input logic [127:0] er);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd; v.mr = mr;
    v.eo = eo; v.ea = ea; v.ew = ew; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drop_all;
    ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwr = 1'b0; daddr = '0; dwdata = '0; mrdata = '0;
  endtask

  // Hold reset, confirm every output is cleared, release on a falling edge.
  task automatic reset_dut(input string nm);
    drop_all();
    rst = 1'b1;
    #1;
    chk({nm, "_ctl"}, {89'b0, outs, maddr}, 128'h0);
    chk({nm, "_data"}, mwdata | rdata, 128'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single I read at 0x100, then D write with I arriving mid-transfer.
    for (int k = 0; k < 5; k++)
      add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, '0, MB + 128'(k), O_ACC_I, 32'h100, '0, '0);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, '0, MB + 128'd5, O_RSP_I, 32'h100, '0, MB + 128'd5);
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, '0, MB + 128'd6, O_IDLE, '0, '0, MB + 128'd5);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, MB + 128'd7, O_IDLE, '0, '0, MB + 128'd5);
    for (int r = 0; r < 5; r++)
      add(r >= 2, 32'h180, 1'b1, 1'b1, 32'h2000, WB, MB + 128'(8 + r), O_ACC_DW, 32'h2000, WB,
          MB + 128'd5);
    add(1'b1, 32'h180, 1'b1, 1'b1, 32'h2000, WB, MB + 128'd13, O_RSP_D, '0, '0, MB + 128'd5);
    add(1'b1, 32'h180, 1'b1, 1'b1, 32'h2000, WB, MB + 128'd14, O_IDLE, '0, '0, MB + 128'd5);
    for (int r = 0; r < 5; r++)
      add(1'b1, 32'h180, 1'b0, 1'b0, 32'h0, '0, MB + 128'(15 + r), O_ACC_I, 32'h180, '0,
          MB + 128'd5);
    add(1'b1, 32'h180, 1'b0, 1'b0, 32'h0, '0, MB + 128'd20, O_RSP_I, '0, '0, MB + 128'd20);
    add(1'b1, 32'h180, 1'b0, 1'b0, 32'h0, '0, MB + 128'd21, O_IDLE, '0, '0, MB + 128'd20);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, MB + 128'd22, O_IDLE, '0, '0, MB + 128'd20);

    reset_dut("rst_init");

    foreach (tbl[i]) begin
      ireq = tbl[i].ir; iaddr = tbl[i].ia; dreq = tbl[i].dr; dwr = tbl[i].dw;
      daddr = tbl[i].da; dwdata = tbl[i].wd; mrdata = tbl[i].mr;
      tick();
      vec_cnt++;
      if (outs !== tbl[i].eo || rdata !== tbl[i].er ||
          (tbl[i].eo[2] && maddr !== tbl[i].ea) || (tbl[i].eo[1] && mwdata !== tbl[i].ew)) begin
        err_cnt++;
        $display("FAIL vec%0d: got outs=%b addr=%h wdata=%h rdata=%h expected outs=%b addr=%h wdata=%h rdata=%h",
                 i, outs, maddr, mwdata, rdata, tbl[i].eo, tbl[i].ea, tbl[i].ew, tbl[i].er);
      end
    end

    // Both sides request continuously: D wins the first tie, then strict alternation.
    reset_dut("rst_rr");
    ireq = 1'b1; iaddr = 32'h400; dreq = 1'b1; dwr = 1'b0; daddr = 32'h800;
    for (int c = 0; c < 56; c++) begin
      int n, p, k;
      logic od, acc, rsp;
      mrdata = 128'(c);
      tick();
      n = c + 1; p = (n - 1) % 7; k = (n - 1) / 7;
      od = (k % 2) == 0;
      acc = p <= 4;
      rsp = p == 5;
      chk($sformatf("rr_cyc%0d", n), {122'b0, ig & dg, ig, dg, irv, drv, mreq},
          {122'b0, 1'b0, (acc | rsp) & !od, (acc | rsp) & od, rsp & !od, rsp & od, acc});
      if (acc) chk($sformatf("rr_addr%0d", n), {96'b0, maddr}, od ? 128'h800 : 128'h400);
      if (rsp) chk($sformatf("rr_data%0d", n), rdata, 128'(n - 1));
    end

    // Reset lands in the third ACCESS cycle; the held request restarts afterwards.
    reset_dut("rst_after_rr");
    ireq = 1'b1; iaddr = 32'h300;
    tick(); tick(); tick();
    chk("mid_pre", {121'b0, outs}, {121'b0, O_ACC_I});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {89'b0, outs, maddr}, 128'h0);
    chk("mid_rst_data", mwdata | rdata, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk($sformatf("restart%0d", j), {125'b0, irv, drv, mreq},
          {125'b0, j == 6, 1'b0, j <= 5});
      if (j == 6) ireq = 1'b0;
    end

    // Single-cycle access on the MEM_LATENCY=1 instance.
    reset_dut("rst_l1");
    dreq = 1'b1; dwr = 1'b0; daddr = 32'h40; mrdata = MB + 128'd99;
    tick();
    chk("l1_acc", {96'b0, l1_dg, l1_mreq, l1_drv, l1_maddr[28:0]}, {96'b0, 3'b110, 29'h40});
    mrdata = MB + 128'd77;
    tick();
    chk("l1_resp", {125'b0, l1_dg, l1_mreq, l1_drv}, {125'b0, 3'b101});
    chk("l1_data", l1_rdata, MB + 128'd77);
    dreq = 1'b0;
    tick();
    chk("l1_idle", {124'b0, l1_dg, l1_mreq, l1_drv, l1_busy}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
